// File: rtl/tt_wb_ctrl_seq.sv
// rtl/tt_wb_ctrl_seq.sv - Wishbone-programmed reset/increment/enable sequencer for the tt_top mux control spine
module tt_wb_ctrl_seq #(
  parameter int unsigned SEL_W    = 10,
  parameter int unsigned PULSE_W  = 2,
  parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        ctrl_sel_rst_n,
  output logic        ctrl_sel_inc,
  output logic        ctrl_ena,
  output logic        irq
);

  localparam int unsigned   TW     = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(PULSE_W - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RST    = 3'd1;
  localparam logic [2:0] S_INC_HI = 3'd2;
  localparam logic [2:0] S_INC_LO = 3'd3;
  localparam logic [2:0] S_ENA    = 3'd4;

  localparam logic [1:0] R_CTRL   = 2'd0;
  localparam logic [1:0] R_STATUS = 2'd1;
  localparam logic [1:0] R_ABORT  = 2'd2;

  logic [2:0]       state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] cnt_q, cnt_d;
  logic             ena_req_q, ena_req_d;
  logic             irq_en_q, irq_en_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             ack_q, ack_d;
  logic [31:0]      dat_q, dat_d;
  logic             sel_rst_n_q, sel_rst_n_d;
  logic             inc_q, inc_d;
  logic             ena_q, ena_d;
  logic             irq_q, irq_d;

  logic             req;
  logic             wr;
  logic             busy;
  logic             phase_end;
  logic [SEL_W-1:0] cnt_inc;
  logic [31:0]      lane_mask;
  logic [31:0]      rdata;
  logic             unused_bits;

  assign unused_bits = ^{wbs_adr_i[1:0], wbs_dat_i};

  always_comb begin
    req       = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:4] == BASE_ADR[31:4]) & ~ack_q;
    wr        = req & wbs_we_i;
    busy      = (state_q != S_IDLE);
    phase_end = (timer_q == T_LAST);
    cnt_inc   = cnt_q + 1'b1;
    lane_mask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};

    rdata = '0;
    case (wbs_adr_i[3:2])
      R_CTRL: begin
        rdata[SEL_W-1:0] = sel_q;
        rdata[16]        = ena_req_q;
        rdata[17]        = irq_en_q;
      end
      R_STATUS: begin
        rdata[0]          = busy;
        rdata[1]          = done_q;
        rdata[2]          = err_q;
        rdata[16 +: SEL_W] = cnt_q;
      end
      default: rdata = '0;
    endcase

    ack_d       = req;
    dat_d       = (req & ~wbs_we_i) ? rdata : 32'd0;
    state_d     = state_q;
    timer_d     = timer_q;
    sel_d       = sel_q;
    cnt_d       = cnt_q;
    ena_req_d   = ena_req_q;
    irq_en_d    = irq_en_q;
    done_d      = done_q;
    err_d       = err_q;
    sel_rst_n_d = sel_rst_n_q;
    inc_d       = inc_q;
    ena_d       = ena_q;

    if (busy) timer_d = phase_end ? '0 : timer_q + 1'b1;

    case (state_q)
      S_IDLE: ;
      S_RST: if (phase_end) begin
        sel_rst_n_d = 1'b1;
        if (sel_q != '0) begin
          state_d = S_INC_HI;
          inc_d   = 1'b1;
        end else begin
          state_d = S_ENA;
          ena_d   = ena_req_q;
        end
      end
      S_INC_HI: if (phase_end) begin
        state_d = S_INC_LO;
        inc_d   = 1'b0;
      end
      S_INC_LO: if (phase_end) begin
        cnt_d = cnt_inc;
        if (cnt_inc < sel_q) begin
          state_d = S_INC_HI;
          inc_d   = 1'b1;
        end else begin
          state_d = S_ENA;
          ena_d   = ena_req_q;
        end
      end
      S_ENA: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // Register writes override the sequencer; a done-clear loses to the ENA set.
    if (wr) begin
      case (wbs_adr_i[3:2])
        R_CTRL: begin
          if (busy) begin
            err_d = 1'b1;
            if (wbs_sel_i[2]) irq_en_d = wbs_dat_i[17];
          end else begin
            sel_d = (sel_q & ~lane_mask[SEL_W-1:0]) | (wbs_dat_i[SEL_W-1:0] & lane_mask[SEL_W-1:0]);
            if (wbs_sel_i[2]) begin
              ena_req_d = wbs_dat_i[16];
              irq_en_d  = wbs_dat_i[17];
            end
            done_d      = 1'b0;
            cnt_d       = '0;
            state_d     = S_RST;
            timer_d     = '0;
            sel_rst_n_d = 1'b0;
            inc_d       = 1'b0;
            ena_d       = 1'b0;
          end
        end
        R_STATUS: begin
          if (wbs_dat_i[1] && (state_q != S_ENA)) done_d = 1'b0;
          if (wbs_dat_i[2]) err_d = 1'b0;
        end
        R_ABORT: begin
          state_d     = S_IDLE;
          timer_d     = '0;
          sel_rst_n_d = 1'b0;
          inc_d       = 1'b0;
          ena_d       = 1'b0;
        end
        default: ;
      endcase
    end

    irq_d = done_d & irq_en_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      sel_q       <= '0;
      cnt_q       <= '0;
      ena_req_q   <= 1'b0;
      irq_en_q    <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      ack_q       <= 1'b0;
      dat_q       <= '0;
      sel_rst_n_q <= 1'b0;
      inc_q       <= 1'b0;
      ena_q       <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      ena_req_q   <= ena_req_d;
      irq_en_q    <= irq_en_d;
      done_q      <= done_d;
      err_q       <= err_d;
      ack_q       <= ack_d;
      dat_q       <= dat_d;
      sel_rst_n_q <= sel_rst_n_d;
      inc_q       <= inc_d;
      ena_q       <= ena_d;
      irq_q       <= irq_d;
    end
  end

  assign wbs_ack_o      = ack_q;
  assign wbs_dat_o      = dat_q;
  assign ctrl_sel_rst_n = sel_rst_n_q;
  assign ctrl_sel_inc   = inc_q;
  assign ctrl_ena       = ena_q;
  assign irq            = irq_q;

endmodule

// File: tb/tb_tt_wb_ctrl_seq.sv
// tb/tb_tt_wb_ctrl_seq.sv - randomized self-checking bench for tt_wb_ctrl_seq against a timeline model
`timescale 1ns/1ps
module tb_tt_wb_ctrl_seq;
  localparam int          SEL_W = 10;
  localparam int          PW    = 2;
  localparam logic [31:0] A_CTRL = 32'h3000_0000;
  localparam logic [31:0] A_STAT = 32'h3000_0004;
  localparam logic [31:0] A_ABRT = 32'h3000_0008;
  localparam logic [31:0] A_RSVD = 32'h3000_000C;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wbs_stb_i = 1'b0, wbs_cyc_i = 1'b0, wbs_we_i = 1'b0;
  logic [3:0]  wbs_sel_i = 4'h0;
  logic [31:0] wbs_adr_i = '0, wbs_dat_i = '0;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena, irq;

  always #5 clk = ~clk;

  tt_wb_ctrl_seq #(.SEL_W(SEL_W), .PULSE_W(PW), .BASE_ADR(32'h3000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .ctrl_sel_rst_n(ctrl_sel_rst_n), .ctrl_sel_inc(ctrl_sel_inc),
    .ctrl_ena(ctrl_ena), .irq(irq)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: a sequence is a timeline indexed by cycles since the starting write.
  bit          m_ack, m_rst, m_inc, m_ena, m_irq;
  logic [31:0] m_dat;
  int          m_sel, m_cnt, m_t;
  bit          m_ena_req, m_irq_en, m_done, m_err, m_active;

  function automatic int seq_len(input int s);
    return PW * (1 + 2 * s) + 1;
  endfunction

  function automatic void seq_at(input int t);
    if (t < PW) begin
      m_rst = 0; m_inc = 0; m_ena = 0; m_cnt = 0;
    end else if (t < PW + 2 * PW * m_sel) begin
      m_rst = 1; m_ena = 0;
      m_cnt = (t - PW) / (2 * PW);
      m_inc = ((t - PW) % (2 * PW)) < PW;
    end else begin
      m_rst = 1; m_inc = 0; m_ena = m_ena_req; m_cnt = m_sel;
    end
  endfunction

  function automatic logic [31:0] model_read(input logic [1:0] r);
    if (r == 2'd0) return 32'(m_sel) | (32'(m_ena_req) << 16) | (32'(m_irq_en) << 17);
    if (r == 2'd1) return (32'(m_cnt) << 16) | (32'(m_err) << 2) | (32'(m_done) << 1) | 32'(m_active);
    return 32'd0;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model_step
    bit         req, was_active;
    logic [1:0] r;
    if (!rst_n) begin
      m_ack = 0; m_dat = '0; m_rst = 0; m_inc = 0; m_ena = 0; m_irq = 0;
      m_sel = 0; m_cnt = 0; m_t = 0; m_ena_req = 0; m_irq_en = 0;
      m_done = 0; m_err = 0; m_active = 0;
    end else begin
      req = wbs_stb_i && wbs_cyc_i && (wbs_adr_i[31:4] == 28'h300_0000) && !m_ack;
      r = wbs_adr_i[3:2];
      was_active = m_active;
      m_dat = (req && !wbs_we_i) ? model_read(r) : 32'd0;
      m_ack = req;
      if (req && wbs_we_i && r == 2'd1) begin
        if (wbs_dat_i[1]) m_done = 0;
        if (wbs_dat_i[2]) m_err = 0;
      end
      if (m_active) begin
        m_t++;
        if (m_t == seq_len(m_sel)) begin
          m_active = 0;
          m_done = 1;
        end else begin
          seq_at(m_t);
        end
      end
      if (req && wbs_we_i && r == 2'd0) begin
        if (was_active) begin
          m_err = 1;
          if (wbs_sel_i[2]) m_irq_en = wbs_dat_i[17];
        end else begin
          if (wbs_sel_i[0]) m_sel = (m_sel & 32'h300) | int'(wbs_dat_i[7:0]);
          if (wbs_sel_i[1]) m_sel = (m_sel & 32'h0FF) | (int'(wbs_dat_i[9:8]) << 8);
          if (wbs_sel_i[2]) begin
            m_ena_req = wbs_dat_i[16];
            m_irq_en  = wbs_dat_i[17];
          end
          m_done = 0; m_active = 1; m_t = 0;
          seq_at(0);
        end
      end
      if (req && wbs_we_i && r == 2'd2) begin
        m_active = 0; m_rst = 0; m_inc = 0; m_ena = 0;
      end
      m_irq = m_done && m_irq_en;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_ack",   32'(wbs_ack_o),      32'(m_ack));
      check("cyc_dat",   wbs_dat_o,           m_dat);
      check("cyc_rst_n", 32'(ctrl_sel_rst_n), 32'(m_rst));
      check("cyc_inc",   32'(ctrl_sel_inc),   32'(m_inc));
      check("cyc_ena",   32'(ctrl_ena),       32'(m_ena));
      check("cyc_irq",   32'(irq),            32'(m_irq));
    end
  end

  task automatic wb_xfer(input logic [31:0] a, input bit w, input logic [31:0] d, input logic [3:0] s,
                         input int max_wait, output logic [31:0] rd, output bit acked);
    wbs_stb_i = 1; wbs_cyc_i = 1; wbs_we_i = w; wbs_adr_i = a; wbs_dat_i = d; wbs_sel_i = s;
    acked = 0; rd = '0;
    for (int i = 0; i < max_wait && !acked; i++) begin
      @(negedge clk);
      if (wbs_ack_o) begin
        acked = 1;
        rd = wbs_dat_o;
      end
    end
    wbs_stb_i = 0; wbs_cyc_i = 0; wbs_we_i = 0;
  endtask

  task automatic wb_wr(input string nm, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] rd;
    bit acked;
    wb_xfer(a, 1'b1, d, 4'hF, 4, rd, acked);
    check({nm, "_ack"}, 32'(acked), 32'd1);
  endtask

  task automatic wb_rd(input string nm, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    bit acked;
    wb_xfer(a, 1'b0, 32'd0, 4'hF, 4, rd, acked);
    check({nm, "_ack"}, 32'(acked), 32'd1);
    check(nm, rd, exp);
  endtask

  task automatic wait_inc(input string nm, input bit v);
    for (int i = 0; i < 64 && ctrl_sel_inc !== v; i++) @(negedge clk);
    check(nm, 32'(ctrl_sel_inc), 32'(v));
  endtask

  task automatic observe(input int ncyc, output int rst_low, output int inc_hi,
                         output int inc_rise, output int first_ena);
    bit prev;
    rst_low = 0; inc_hi = 0; inc_rise = 0; first_ena = -1; prev = 0;
    for (int c = 0; c < ncyc; c++) begin
      if (!ctrl_sel_rst_n) rst_low++;
      if (ctrl_sel_inc) inc_hi++;
      if (ctrl_sel_inc && !prev) inc_rise++;
      prev = ctrl_sel_inc;
      if (ctrl_ena && first_ena < 0) first_ena = c;
      @(negedge clk);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          rl, ih, ir, fe;
    int          kind, sv;
    bit          big_done, acked;
    logic [31:0] a, d, rd;
    logic [3:0]  s;

    repeat (3) @(negedge clk);
    chk_en = 1;
    check("reset_ack",   32'(wbs_ack_o), 32'd0);
    check("reset_dat",   wbs_dat_o, 32'd0);
    check("reset_rst_n", 32'(ctrl_sel_rst_n), 32'd0);
    check("reset_inc",   32'(ctrl_sel_inc), 32'd0);
    check("reset_ena",   32'(ctrl_ena), 32'd0);
    check("reset_irq",   32'(irq), 32'd0);
    rst_n = 1;
    @(negedge clk);
    wb_rd("reset_status", A_STAT, 32'd0);
    wb_rd("reset_ctrl",   A_CTRL, 32'd0);

    // T1: asynchronous reset in the middle of an increment-high phase
    wb_wr("t1_ctrl", A_CTRL, 32'h0001_0003);
    wait_inc("t1_wait_hi", 1'b1);
    @(posedge clk); #1;
    check("t1_pre_inc", 32'(ctrl_sel_inc), 32'd1);
    #1 rst_n = 0;
    #1;
    check("t1_inc",   32'(ctrl_sel_inc), 32'd0);
    check("t1_rst_n", 32'(ctrl_sel_rst_n), 32'd0);
    check("t1_ena",   32'(ctrl_ena), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    wb_rd("t1_status", A_STAT, 32'd0);

    // T2: sel=3, ena_req=1
    wb_wr("t2_ctrl", A_CTRL, 32'h0001_0003);
    observe(40, rl, ih, ir, fe);
    check("t2_rst_low", 32'(rl), 32'd2);
    check("t2_inc_hi",  32'(ih), 32'd6);
    check("t2_inc_cnt", 32'(ir), 32'd3);
    check("t2_ena_at",  32'(fe), 32'd14);
    check("t2_ena_end", 32'(ctrl_ena), 32'd1);
    wb_rd("t2_status", A_STAT, 32'h0003_0002);
    wb_rd("t2_ctrl_rd", A_CTRL, 32'h0001_0003);

    // T3: sel=0, ena_req=0
    wb_wr("t3_ctrl", A_CTRL, 32'h0000_0000);
    observe(10, rl, ih, ir, fe);
    check("t3_rst_low", 32'(rl), 32'd2);
    check("t3_inc_hi",  32'(ih), 32'd0);
    check("t3_ena_at",  32'(fe), 32'hFFFF_FFFF);
    check("t3_rst_n",   32'(ctrl_sel_rst_n), 32'd1);
    wb_rd("t3_status", A_STAT, 32'h0000_0002);

    // T4: CTRL write while busy in INC_LO
    wb_wr("t4_ctrl", A_CTRL, 32'h0001_0005);
    wait_inc("t4_wait_hi", 1'b1);
    wait_inc("t4_wait_lo", 1'b0);
    wb_wr("t4_busy_ctrl", A_CTRL, 32'h0002_0007);
    observe(60, rl, ih, ir, fe);
    check("t4_inc_rest", 32'(ir), 32'd4);
    check("t4_ena_at",   32'(fe), 32'd17);
    check("t4_irq",      32'(irq), 32'd1);
    wb_rd("t4_ctrl_rd", A_CTRL, 32'h0003_0005);
    wb_rd("t4_status",  A_STAT, 32'h0005_0006);
    wb_wr("t4_w1c", A_STAT, 32'h0000_0006);
    wb_rd("t4_status_clr", A_STAT, 32'h0005_0000);
    check("t4_irq_clr", 32'(irq), 32'd0);

    // T5: ABORT during INC_HI with irq_en=1
    wb_wr("t5_ctrl", A_CTRL, 32'h0002_0004);
    wait_inc("t5_wait_hi", 1'b1);
    wb_wr("t5_abort", A_ABRT, 32'h0000_0000);
    check("t5_rst_n", 32'(ctrl_sel_rst_n), 32'd0);
    check("t5_ena",   32'(ctrl_ena), 32'd0);
    check("t5_inc",   32'(ctrl_sel_inc), 32'd0);
    observe(10, rl, ih, ir, fe);
    check("t5_inc_hi",  32'(ih), 32'd0);
    check("t5_rst_low", 32'(rl), 32'd10);
    check("t5_irq",     32'(irq), 32'd0);
    wb_rd("t5_status",  A_STAT, 32'h0000_0000);
    wb_rd("t5_abort_rd", A_ABRT, 32'h0000_0000);

    // T6: reserved register and an undecoded address
    wb_rd("t6_rsvd", A_RSVD, 32'h0000_0000);
    wb_xfer(32'h3000_0010, 1'b0, 32'd0, 4'hF, 16, rd, acked);
    check("t6_nodecode_ack", 32'(acked), 32'd0);

    // Randomized traffic against the model
    big_done = 0;
    for (int n = 0; n < 220; n++) begin
      kind = $urandom_range(0, 99);
      s = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      if (kind < 32) begin
        sv = $urandom_range(0, 6);
        if (!big_done && $urandom_range(0, 40) == 0) begin
          sv = 1023;
          big_done = 1;
        end
        d = ($urandom & 32'hFFFF_FC00) | 32'(sv);
        wb_xfer(A_CTRL, 1'b1, d, s, 4, rd, acked);
      end else if (kind < 45) begin
        wb_xfer(A_STAT, 1'b1, $urandom, s, 4, rd, acked);
      end else if (kind < 52) begin
        wb_xfer(A_ABRT, 1'b1, $urandom, s, 4, rd, acked);
      end else if (kind < 80) begin
        a = A_CTRL | (32'($urandom_range(0, 3)) << 2);
        wb_xfer(a, 1'b0, 32'd0, s, 4, rd, acked);
      end else if (kind < 88) begin
        wb_xfer(A_RSVD, 1'b1, $urandom, s, 4, rd, acked);
      end else if (kind < 97) begin
        a = 32'h3000_0010 | ($urandom & 32'h0FFF_FFFC);
        wb_xfer(a, $urandom_range(0, 1) == 1, $urandom, s, 3, rd, acked);
      end else begin
        @(posedge clk);
        #2 rst_n = 0;
        @(negedge clk); @(negedge clk);
        rst_n = 1;
      end
      repeat ($urandom_range(0, 40)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
